// File: rtl/adder_pkg.sv
// Shared types for the digit-serial adder.
// The digit count and index width depend on the instance parameters, so they are derived in the top module.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } adder_state_t;

endpackage

// File: rtl/adder_slice.sv
// Combinational K-bit adder digit: sum, carry out, and carry into the MSB.
// The carry into the MSB feeds the signed overflow detection on the last digit.
module adder_slice #(
    parameter int K = 8
) (
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    input  logic         cin,
    output logic [K-1:0] sum,
    output logic         cout,
    output logic         carry_msb
);

    logic [K:0] full;

    // The extra top bit keeps the digit carry, so nothing is lost between digits.
    assign full      = {1'b0, a} + {1'b0, b} + {{K{1'b0}}, cin};
    assign sum       = full[K-1:0];
    assign cout      = full[K];
    assign carry_msb = sum[K-1] ^ a[K-1] ^ b[K-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: one K-bit digit per clock, LSB digit first.
// One adder_slice is reused for every digit; valid/ready handshakes sit on both sides.
module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int N = 32,
    parameter int K = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int D    = (K >= 1) ? N / K : 1;
    localparam int IDXW = (D > 1) ? $clog2(D) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(D - 1);

    if (K < 1) begin : g_bad_k
        $error("digit_serial_adder: K must be at least 1");
    end else if (N % K != 0) begin : g_bad_nk
        $error("digit_serial_adder: N must be a multiple of K");
    end

    adder_state_t    state;
    adder_state_t    next_state;
    logic [N-1:0]    a_reg;
    logic [N-1:0]    b_reg;
    logic            carry;
    logic [IDXW-1:0] idx;

    logic [K-1:0]    digit_a;
    logic [K-1:0]    digit_b;
    logic [K-1:0]    digit_sum;
    logic            digit_cout;
    logic            digit_carry_msb;

    assign digit_a = a_reg[idx*K +: K];
    assign digit_b = b_reg[idx*K +: K];

    adder_slice #(.K(K)) u_slice (
        .a         (digit_a),
        .b         (digit_b),
        .cin       (carry),
        .sum       (digit_sum),
        .cout      (digit_cout),
        .carry_msb (digit_carry_msb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (idx == LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Subtraction is a + ~b + ~cin, so inversion happens once at capture time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= sub ? ~b : b;
                        carry <= sub ? ~cin : cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    sum[idx*K +: K] <= digit_sum;
                    carry           <= digit_cout;
                    if (idx == LAST) begin
                        idx  <= '0;
                        cout <= digit_cout;
                        ovf  <= digit_carry_msb ^ digit_cout;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench for digit_serial_adder: a 32/8 instance and an 8/8 single-digit instance.
// Stimulus pushes expected results; per-instance monitors pop them when out_valid rises.
module tb_digit_serial_adder;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int          cycle;
    int          checks;
    int          errors;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        cin8;
    logic        sub8;
    logic        out_valid8;
    logic        out_ready8;
    logic [7:0]  sum8;
    logic        cout8;
    logic        ovf8;

    exp_t q32[$];
    exp_t q8[$];
    logic prev32;
    logic prev8;

    digit_serial_adder #(.N(32), .K(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    digit_serial_adder #(.N(8), .K(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .sub       (sub8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum       (sum8),
        .cout      (cout8),
        .ovf       (ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endfunction

    function automatic void reportTimeout(string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timed out waiting for the DUT", name);
    endfunction

    always @(negedge clk) begin : mon32
        exp_t e;
        if (!rst_n) begin
            prev32 = 1'b0;
        end else begin
            if (out_valid && !prev32) begin
                if (q32.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_result32: got sum 0x%0h, expected no result", sum);
                end else begin
                    e = q32.pop_front();
                    checkOutput("sum32", sum, e.sum);
                    checkOutput("cout32", 32'(cout), 32'(e.cout));
                    checkOutput("ovf32", 32'(ovf), 32'(e.ovf));
                    checkOutput("latency32", 32'(cycle - e.acc), 32'(e.lat));
                end
            end
            prev32 = out_valid;
        end
    end

    always @(negedge clk) begin : mon8
        exp_t e;
        if (!rst_n) begin
            prev8 = 1'b0;
        end else begin
            if (out_valid8 && !prev8) begin
                if (q8.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_result8: got sum 0x%0h, expected no result", sum8);
                end else begin
                    e = q8.pop_front();
                    checkOutput("sum8", 32'(sum8), e.sum);
                    checkOutput("cout8", 32'(cout8), 32'(e.cout));
                    checkOutput("ovf8", 32'(ovf8), 32'(e.ovf));
                    checkOutput("latency8", 32'(cycle - e.acc), 32'(e.lat));
                end
            end
            prev8 = out_valid8;
        end
    end

    task automatic applyStimulus(input bit use8, input logic [31:0] va, input logic [31:0] vb,
                                 input logic vcin, input logic vsub, input logic [31:0] esum,
                                 input logic ecout, input logic eovf);
        exp_t e;
        int   n;
        @(negedge clk);
        if (use8) begin
            a8 = va[7:0]; b8 = vb[7:0]; cin8 = vcin; sub8 = vsub; in_valid8 = 1'b1;
        end else begin
            a = va; b = vb; cin = vcin; sub = vsub; in_valid = 1'b1;
        end
        n = 0;
        while (!(use8 ? in_ready8 : in_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            reportTimeout("accept");
        end
        @(posedge clk);
        #1;
        e.sum  = esum;
        e.cout = ecout;
        e.ovf  = eovf;
        e.acc  = cycle;
        e.lat  = use8 ? 1 : 4;
        if (use8) begin
            q8.push_back(e);
            in_valid8 = 1'b0; a8 = ~a8; b8 = ~b8; sub8 = ~sub8; cin8 = ~cin8;
        end else begin
            q32.push_back(e);
            in_valid = 1'b0; a = ~a; b = ~b; sub = ~sub; cin = ~cin;
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((q32.size() != 0 || q8.size() != 0 || out_valid || out_valid8) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            reportTimeout("drain");
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   n;
        logic seen;
        cycle      = 0;
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        cin        = 1'b0;
        sub        = 1'b0;
        out_ready  = 1'b1;
        in_valid8  = 1'b0;
        a8         = '0;
        b8         = '0;
        cin8       = 1'b0;
        sub8       = 1'b0;
        out_ready8 = 1'b1;

        #12;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_sum", sum, 32'h0);
        checkOutput("rst_cout", 32'(cout), 32'd0);
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
        checkOutput("rst_sum8", 32'(sum8), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(0, 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0);
        waitDrain();
        applyStimulus(0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
        waitDrain();
        applyStimulus(0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
        waitDrain();
        applyStimulus(0, 32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        waitDrain();
        applyStimulus(0, 32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000001, 1'b1, 1'b0);
        waitDrain();
        applyStimulus(0, 32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0);
        waitDrain();
        applyStimulus(0, 32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
        waitDrain();
        applyStimulus(0, 32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, 32'h01000100, 1'b0, 1'b0);
        waitDrain();

        // Backpressure: result must hold while operands and in_valid churn.
        out_ready = 1'b0;
        applyStimulus(0, 32'hAAAA0000, 32'h00005555, 1'b0, 1'b0, 32'hAAAA5555, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            reportTimeout("bp_valid");
        end
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_sum", sum, 32'hAAAA5555);
            checkOutput("bp_cout", 32'(cout), 32'd0);
            checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            in_valid = 1'b1;
            a        = $urandom;
            b        = $urandom;
            sub      = 1'(i);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_release_valid", 32'(out_valid), 32'd0);
        checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
        waitDrain();

        // Abort during the third digit; nothing may surface afterwards.
        applyStimulus(0, 32'h11111111, 32'h22222222, 1'b0, 1'b0, 32'h33333333, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        q32.delete();
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_sum", sum, 32'h0);
        checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("abort_release_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checkOutput("abort_no_stale", 32'(seen), 32'd0);

        applyStimulus(0, 32'h00000010, 32'h00000020, 1'b0, 1'b0, 32'h00000030, 1'b0, 1'b0);
        waitDrain();

        applyStimulus(1, 32'h80, 32'h80, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1);
        waitDrain();
        applyStimulus(1, 32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1);
        waitDrain();
        applyStimulus(1, 32'h03, 32'h05, 1'b0, 1'b1, 32'hFE, 1'b0, 1'b0);
        waitDrain();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
